control_sequencer: RTL and testbench

Hardwired control unit that drives every control input of `DataPath` for the phase-1 instruction subset. It sits directly upstream of the datapath: it consumes the IR contents and sequences fetch and execute one control step per clock. It replaces the hand-scripted step sequences used in the per-instruction benches. It is a Moore machine: all outputs decode from the current state and the latched opcode only.

---
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 tb/tb_control_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the phase-1 datapath.
// Fetch (T0-T2), then per-opcode execute steps E3-E7, or HALTED.
module control_sequencer (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        incPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  Operator,
  output logic        Run
);

  localparam logic [4:0] ADD_OP  = 5'b00011;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2,
    S_E3, S_E4, S_E5, S_E6, S_E7,
    S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;

  logic is_ld, is_ldi, is_st, is_r, is_addi, is_halt;
  logic is_mem, is_alu;
  logic unused_ir;

  assign unused_ir = ^IR[26:0];

  assign is_ld   = (op_q == OP_LD);
  assign is_ldi  = (op_q == OP_LDI);
  assign is_st   = (op_q == OP_ST);
  assign is_addi = (op_q == OP_ADDI);
  assign is_halt = (op_q == OP_HALT);
  assign is_r    = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_AND) || (op_q == OP_OR);
  assign is_mem  = is_ld || is_ldi || is_st;
  assign is_alu  = is_r || is_addi;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode is captured only as IR is loaded, so later IR edits are ignored.
  always_comb begin
    op_d = op_q;
    if (state_q == S_T2) op_d = IR[31:27];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_E3;
      S_E3: begin
        if (is_mem || is_alu) state_d = S_E4;
        else if (is_halt)     state_d = S_HALT;
        else                  state_d = S_T0;
      end
      S_E4:   state_d = S_E5;
      S_E5:   state_d = (is_ld || is_st) ? S_E6 : S_T0;
      S_E6:   state_d = S_E7;
      S_E7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    Rout  = 1'b0; BAout   = 1'b0; Cout   = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin  = 1'b0; Yin = 1'b0; Rin  = 1'b0;
    Gra   = 1'b0; Grb = 1'b0; Grc  = 1'b0;
    incPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Operator = 5'b0;
    Run = (state_q != S_RST) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1;
        incPC = 1'b1; Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin  = 1'b1;
        Read    = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_E3: begin
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      S_E4: begin
        Zin = 1'b1;
        if (is_r) begin
          Grc = 1'b1; Rout = 1'b1; Operator = op_q;
        end else begin
          Cout = 1'b1; Operator = ADD_OP;
        end
      end
      S_E5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) MARin = 1'b1;
        else begin
          Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_E6: begin
        MDRin = 1'b1;
        if (is_ld) Read = 1'b1;
        else begin
          Gra = 1'b1; Rout = 1'b1;
        end
      end
      S_E7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-step expected
// control words are queued per instruction and popped each cycle.
module tb_control_sequencer;

  typedef struct packed {
    logic pcout, zlowout, mdrout, rout, baout, cout;
    logic marin, zin, pcin, mdrin, irin, yin, rin;
    logic gra, grb, grc;
    logic incpc, read, write, run;
    logic [4:0] op;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = '0;

  logic PCout, Zlowout, MDRout, Rout, BAout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic Gra, Grb, Grc, incPC, Read, Write, Run;
  logic [4:0] Operator;

  ctl_t obs;
  ctl_t sb[$];
  int   total = 0;
  int   bad = 0;

  control_sequencer dut (
    .clk(clk), .clear(clear), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .incPC(incPC), .Read(Read), .Write(Write),
    .Operator(Operator), .Run(Run)
  );

  always #5 clk = ~clk;

  assign obs = '{pcout: PCout, zlowout: Zlowout, mdrout: MDRout,
                 rout: Rout, baout: BAout, cout: Cout,
                 marin: MARin, zin: Zin, pcin: PCin, mdrin: MDRin,
                 irin: IRin, yin: Yin, rin: Rin,
                 gra: Gra, grb: Grb, grc: Grc,
                 incpc: incPC, read: Read, write: Write, run: Run,
                 op: Operator};

  function automatic int nsteps(input logic [4:0] o);
    case (o)
      5'b00000, 5'b00010: nsteps = 8;
      5'b00001, 5'b01100, 5'b00011,
      5'b00100, 5'b00101, 5'b00110: nsteps = 6;
      default: nsteps = 4;
    endcase
  endfunction

  function automatic ctl_t exp_step(input logic [4:0] o, input int k);
    ctl_t e;
    bit ld, st, mem, r, alu;
    ld  = (o == 5'b00000);
    st  = (o == 5'b00010);
    mem = ld || st || (o == 5'b00001);
    r   = (o >= 5'b00011) && (o <= 5'b00110);
    alu = r || (o == 5'b01100);
    e = '0;
    e.run = 1'b1;
    case (k)
      0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1; end
      1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
      2: begin e.mdrout = 1; e.irin = 1; end
      3: begin
        if (mem) begin e.grb = 1; e.baout = 1; e.yin = 1; end
        if (alu) begin e.grb = 1; e.rout = 1; e.yin = 1; end
      end
      4: begin
        e.zin = 1;
        if (r) begin e.grc = 1; e.rout = 1; e.op = o; end
        else begin e.cout = 1; e.op = 5'b00011; end
      end
      5: begin
        e.zlowout = 1;
        if (ld || st) e.marin = 1;
        else begin e.gra = 1; e.rin = 1; end
      end
      6: begin
        e.mdrin = 1;
        if (ld) e.read = 1;
        else begin e.gra = 1; e.rout = 1; end
      end
      7: begin
        if (ld) begin e.mdrout = 1; e.gra = 1; e.rin = 1; end
        else e.write = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] o,
      input logic [3:0] ra, input logic [3:0] rb, input logic [18:0] c);
    return {o, ra, rb, c};
  endfunction

  // Runs one instruction from T0; stop_at >= 0 stops after that step.
  task automatic run_instr(input string name, input logic [31:0] ir,
                           input int stop_at);
    ctl_t e;
    int n;
    n = nsteps(ir[31:27]);
    IR = ir;
    for (int k = 0; k < n; k++) sb.push_back(exp_step(ir[31:27], k));
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s step%0d: got %h want %h", name, k, obs, e);
      end
      if (k == 3) IR = $urandom;
      if (k == stop_at) break;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset: got %h want %h", obs, ctl_t'('0));
    end
    clear = 1'b0;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rst_state: got %h want 0", obs);
    end
  endtask

  task automatic test_fetch_ldi();
    run_instr("ldi", mk(5'b00001, 4'd1, 4'd0, 19'd85), -1);
  endtask

  task automatic test_ld();
    run_instr("ld", mk(5'b00000, 4'd1, 4'd0, 19'd85), -1);
  endtask

  task automatic test_st();
    run_instr("st", mk(5'b00010, 4'd3, 4'd0, 19'd90), -1);
  endtask

  task automatic test_rtype();
    logic [4:0] ops [5];
    ops = '{5'b00100, 5'b00011, 5'b00101, 5'b00110, 5'b01100};
    foreach (ops[i])
      run_instr("alu", mk(ops[i], 4'd4, 4'd5, {4'd6, 15'd0}), -1);
  endtask

  task automatic test_back_to_back();
    run_instr("nop1f", mk(5'b11111, 4'd0, 4'd0, 19'd0), -1);
    run_instr("nop07", mk(5'b00111, 4'd0, 4'd0, 19'd0), -1);
    run_instr("ld_b2b", mk(5'b00000, 4'd2, 4'd1, 19'd4), -1);
    run_instr("st_b2b", mk(5'b00010, 4'd2, 4'd1, 19'd4), -1);
  endtask

  task automatic test_halt();
    ctl_t e;
    run_instr("halt", mk(5'b11011, 4'd0, 4'd0, 19'd0), -1);
    for (int i = 0; i < 20; i++) sb.push_back('0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) IR = mk(5'b00000, 4'd1, 4'd0, 19'd1);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL halted c%0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    run_instr("ld_pre", mk(5'b00000, 4'd1, 4'd0, 19'd85), 6);
    #2;
    clear = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL abort: got %h want 0", obs);
    end
    sb.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    run_instr("refetch", mk(5'b00011, 4'd1, 4'd2, 19'd0), -1);
  endtask

  initial begin
    test_reset();
    test_fetch_ldi();
    test_ld();
    test_st();
    test_rtype();
    test_back_to_back();
    test_halt();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
